prefetch_queue: RTL and testbench

//  Instruction prefetch buffer between the instruction memory and the pipeline IF stage.

---
 rtl/prefetch_queue.sv | 103 ++++++++++
 tb/tb_prefetch_queue.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: issues sequential word fetches to IMEM, buffers
// returned words with their PCs, and presents the head entry to the IF stage.
module prefetch_queue #(
  parameter int          DEPTH = 4,
  parameter int          AW    = 2,
  parameter logic [31:0] NOP   = 32'h54000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] initPC,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        deq,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] incPC
);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} stateT;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entryT;

  stateT       state, stateNxt;
  logic [31:0] fpc, reqAddr;
  logic [AW:0] count;
  logic [AW-1:0] rdPtr, wrPtr;
  entryT       mem [DEPTH];
  logic        issue, push, pop, empty;

  assign empty = (count == '0);
  assign issue = (state == IDLE) && !redirect && (count < (AW+1)'(DEPTH));
  assign push  = (state == WAIT) && imem_ack && !redirect;
  assign pop   = deq && !empty && !redirect;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNxt;
  end

  always_comb begin
    stateNxt = state;
    unique case (state)
      IDLE:    if (issue) stateNxt = WAIT;
      WAIT:    if (imem_ack) stateNxt = IDLE;
               else if (redirect) stateNxt = DROP;
      DROP:    if (imem_ack) stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  always_comb begin
    imem_req  = (state != IDLE);
    imem_addr = reqAddr;
  end

  // reqAddr is latched at issue so the bus address stays put even when a
  // redirect retargets fpc while the request is still in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fpc     <= initPC & 32'hFFFF_FFFC;
      reqAddr <= initPC & 32'hFFFF_FFFC;
      count   <= '0;
      rdPtr   <= '0;
      wrPtr   <= '0;
    end else if (redirect) begin
      fpc   <= redirect_pc & 32'hFFFF_FFFC;
      count <= '0;
      rdPtr <= '0;
      wrPtr <= '0;
    end else begin
      if (issue) reqAddr <= fpc;
      if (push) begin
        wrPtr <= wrPtr + AW'(1);
        fpc   <= fpc + 32'd4;
      end
      if (pop) rdPtr <= rdPtr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= '{instr: imem_data, pc: fpc};
  end

  always_comb begin
    instr_valid = !empty;
    instr       = empty ? NOP : mem[rdPtr].instr;
    instr_pc    = empty ? 32'd0 : mem[rdPtr].pc;
    incPC       = instr_pc + 32'd4;
  end

endmodule

// File: tb/tb_prefetch_queue.sv
// Directed bench for prefetch_queue with a variable-latency IMEM responder.
module tb_prefetch_queue;
  localparam logic [31:0] NOP = 32'h54000000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] initPC = 32'h100;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_data;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        deq = 1'b0;
  logic        instr_valid;
  logic [31:0] instr, instr_pc, incPC;

  int nChk = 0, nPass = 0;
  int lat = 1;
  int cnt = 0;
  bit seen = 1'b0;
  logic [31:0] reqLog[$];

  prefetch_queue dut (
    .clk(clk), .rst(rst), .initPC(initPC),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data),
    .redirect(redirect), .redirect_pc(redirect_pc), .deq(deq),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .incPC(incPC)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return a ^ 32'hC3A5_0000;
  endfunction

  // IMEM model: acks lat cycles after the request becomes visible
  initial begin
    imem_ack  = 1'b0;
    imem_data = 32'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        imem_ack = 1'b0; cnt = 0; seen = 1'b0;
      end else if (imem_ack) begin
        imem_ack = 1'b0; cnt = 0; seen = 1'b0;
      end else if (imem_req) begin
        if (!seen) begin seen = 1'b1; reqLog.push_back(imem_addr); end
        if (cnt >= lat) begin
          imem_ack  = 1'b1;
          imem_data = memWord(imem_addr);
        end else cnt++;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChk++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic waitAck();
    int k = 0;
    while (k < 50) begin
      @(negedge clk); #1;
      if (imem_ack) break;
      k++;
    end
    if (k >= 50) chk("ackTimeout", 32'd0, 32'd1);
  endtask

  initial begin
    // 1: reset state and first fetch with 1-cycle IMEM latency
    tick(2);
    chk("rstReq", {31'd0, imem_req}, 32'd0);
    chk("rstValid", {31'd0, instr_valid}, 32'd0);
    chk("rstInstr", instr, NOP);
    chk("rstPc", instr_pc, 32'd0);
    chk("rstIncPc", incPC, 32'd4);
    rst = 1'b0;
    tick(1);
    chk("firstReq", {31'd0, imem_req}, 32'd1);
    chk("firstAddr", imem_addr, 32'h100);
    tick(1);
    chk("validLate", {31'd0, instr_valid}, 32'd0);
    tick(1);
    chk("validRise", {31'd0, instr_valid}, 32'd1);
    chk("headPc", instr_pc, 32'h100);
    chk("headInc", incPC, 32'h104);
    chk("headInstr", instr, memWord(32'h100));

    // 2: fill with deq held low, then one deq frees one slot
    lat = 0;
    tick(12);
    chk("fillCount", 32'(reqLog.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk("fillAddr", reqLog[i], 32'h100 + 32'(4 * i));
    chk("fullNoReq", {31'd0, imem_req}, 32'd0);
    chk("fullHead", instr_pc, 32'h100);
    deq = 1'b1; tick(1); deq = 1'b0;
    chk("deqHead", instr_pc, 32'h104);
    tick(1);
    chk("refillReq", {31'd0, imem_req}, 32'd1);
    chk("refillAddr", imem_addr, 32'h110);
    tick(4);
    chk("refillCount", 32'(reqLog.size()), 32'd5);
    chk("refillIdle", {31'd0, imem_req}, 32'd0);

    // 4: ack and deq in the same cycle with two entries queued
    lat = 3;
    deq = 1'b1; tick(2); deq = 1'b0;
    chk("twoHead", instr_pc, 32'h10C);
    chk("twoAddr", imem_addr, 32'h114);
    waitAck();
    deq = 1'b1;
    tick(1);
    chk("ackDeqHead", instr_pc, 32'h110);
    chk("ackDeqInstr", instr, memWord(32'h110));
    tick(1);
    chk("orderNext", instr_pc, 32'h114);
    tick(1);
    chk("drainValid", {31'd0, instr_valid}, 32'd0);
    chk("drainInstr", instr, NOP);
    deq = 1'b0;

    // 3: redirect while a request is outstanding -> stale ack dropped
    chk("pendAddr", imem_addr, 32'h118);
    lat = 20;
    redirect = 1'b1; redirect_pc = 32'h203;
    tick(1);
    redirect = 1'b0;
    chk("dropReq", {31'd0, imem_req}, 32'd1);
    chk("dropAddrStable", imem_addr, 32'h118);
    chk("dropEmpty", {31'd0, instr_valid}, 32'd0);
    tick(2);
    chk("dropStillReq", {31'd0, imem_req}, 32'd1);
    lat = 0;
    waitAck();
    tick(1);
    chk("staleDropped", {31'd0, instr_valid}, 32'd0);
    chk("staleReqLow", {31'd0, imem_req}, 32'd0);
    tick(1);
    chk("tgtAddr", imem_addr, 32'h200);
    tick(1);
    chk("tgtPc", instr_pc, 32'h200);
    chk("tgtInc", incPC, 32'h204);
    chk("tgtInstr", instr, memWord(32'h200));

    // 5: redirect coincident with ack in WAIT, plus PC wrap
    lat = 2;
    waitAck();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    tick(1);
    redirect = 1'b0;
    chk("coValid", {31'd0, instr_valid}, 32'd0);
    chk("coReq", {31'd0, imem_req}, 32'd0);
    tick(1);
    chk("coAddr", imem_addr, 32'hFFFF_FFFC);
    chk("coStillEmpty", {31'd0, instr_valid}, 32'd0);
    waitAck();
    tick(1);
    chk("wrapPc", instr_pc, 32'hFFFF_FFFC);
    chk("wrapInc", incPC, 32'd0);
    tick(1);
    chk("wrapAddr", imem_addr, 32'd0);

    // 6: reset mid-request, then deq on an empty queue is ignored
    initPC = 32'h402;
    rst = 1'b1;
    #1;
    chk("asyncReq", {31'd0, imem_req}, 32'd0);
    chk("asyncValid", {31'd0, instr_valid}, 32'd0);
    tick(2);
    rst = 1'b0;
    deq = 1'b1;
    tick(1);
    chk("rstAddr", imem_addr, 32'h400);
    tick(1);
    chk("emptyDeq", {31'd0, instr_valid}, 32'd0);
    deq = 1'b0;
    waitAck();
    tick(1);
    chk("rstHead", instr_pc, 32'h400);
    chk("rstHeadValid", {31'd0, instr_valid}, 32'd1);

    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end
endmodule
